// File: rtl/booth_mult.sv
// Radix-2 Booth sequential 32x32 signed multiplier: 32 RUN cycles per product.
// Optional early exit for zero operands when MULT_ZERO_SHORTCUT_EN is defined.
module booth_mult (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [32:0] acc_q, acc_d;
  logic [32:0] mcand_q, mcand_d;
  logic [31:0] mult_q, mult_d;
  logic        qm1_q, qm1_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [32:0] sum;
  logic        zero_op;

  // start/done handshake: start is sampled only in IDLE; done is a
  // single-cycle pulse meaning HI/LO now hold a new, final product.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum     = acc_q;
    zero_op = 1'b0;
`ifdef MULT_ZERO_SHORTCUT_EN
    zero_op = (A == 32'd0) || (B == 32'd0);
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = 33'd0;
          mult_d  = B;
          qm1_d   = 1'b0;
          mcand_d = {A[31], A};
          cnt_d   = 6'd0;
          if (zero_op) begin
            hi_d    = 32'd0;
            lo_d    = 32'd0;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // 33-bit accumulator keeps -(-2^31) representable
        case ({mult_q[0], qm1_q})
          2'b10:   sum = acc_q - mcand_q;
          2'b01:   sum = acc_q + mcand_q;
          default: sum = acc_q;
        endcase
        acc_d  = {sum[32], sum[32:1]};
        mult_d = {sum[0], mult_q[31:1]};
        qm1_d  = mult_q[0];
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          hi_d    = acc_d[31:0];
          lo_d    = mult_d;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      acc_q   <= 33'd0;
      mcand_q <= 33'd0;
      mult_q  <= 32'd0;
      qm1_q   <= 1'b0;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign HI        = hi_q;
  assign LO        = lo_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

endmodule
